// File: rtl/sw_input.sv
// sw_input: board switch front end -- synchronize, debounce per bit, queue change events.
// Define SW_INPUT_SYNC_EN to insert the 2-flop input synchronizer.
module sw_input #(
    parameter int WIDTH      = 8,
    parameter int DEB_CYCLES = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         sw,
    output logic [WIDTH-1:0]         sw_stable,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [$clog2(WIDTH)-1:0] evt_idx,
    output logic                     evt_level,
    output logic                     evt_coalesced,
    input  logic                     coal_clr
);

    localparam int IW = $clog2(WIDTH);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [PW:0]   FIFO_FULL = (PW+1)'(FIFO_DEPTH);

    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] r_stable;
    logic [CW-1:0]    r_cnt [WIDTH];
    logic [WIDTH-1:0] w_flip;
    logic [WIDTH-1:0] r_pend;
    logic [WIDTH-1:0] w_low_oh;
    logic [WIDTH-1:0] w_clr_oh;
    logic [IW-1:0]    w_push_idx;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_coal;
    logic             r_coal;
    logic [IW:0]      r_mem [FIFO_DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [PW:0]      r_count;

`ifdef SW_INPUT_SYNC_EN
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    // Two-stage synchronizer for the asynchronous switch pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;
`else
    assign w_s = sw;
`endif

    // A bit flips on the cycle its mismatch count would reach DEB_CYCLES.
    always_comb begin
        w_flip = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_flip[i] = (w_s[i] != r_stable[i]) && (r_cnt[i] == DEB_LAST);
        end
    end

    // Per-bit debounce counters and filtered levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (w_s[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_flip[i]) begin
                    r_stable[i] <= w_s[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Lowest pending index wins the single push slot; a re-flip on the pushed bit re-arms it.
    always_comb begin
        w_full     = (r_count == FIFO_FULL);
        w_pop      = evt_valid && evt_ready;
        w_low_oh   = r_pend & (~r_pend + WIDTH'(1));
        w_push     = (r_pend != '0) && !w_full;
        w_clr_oh   = w_push ? w_low_oh : '0;
        w_coal     = |(w_flip & r_pend & ~w_clr_oh);
        w_push_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_push_idx = w_push_idx | (w_low_oh[i] ? IW'(i) : '0);
        end
    end

    // Pending set and sticky coalesce flag (set beats clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
            r_coal <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_clr_oh) | w_flip;
            if (w_coal) begin
                r_coal <= 1'b1;
            end else if (coal_clr) begin
                r_coal <= 1'b0;
            end else begin
                r_coal <= r_coal;
            end
        end
    end

    // Event queue storage; full blocks pushes even when a pop happens the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= {w_push_idx, r_stable[w_push_idx]};
                r_wr        <= r_wr + PW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign sw_stable     = r_stable;
    assign evt_valid     = (r_count != '0);
    assign evt_idx       = r_mem[r_rd][IW:1];
    assign evt_level     = r_mem[r_rd][0];
    assign evt_coalesced = r_coal;

endmodule

// File: tb/tb_sw_input.sv
// Directed bench for sw_input (WIDTH=8, DEB_CYCLES=4, FIFO_DEPTH=4); latencies follow SW_INPUT_SYNC_EN.
module tb_sw_input;

    localparam int DEB = 4;
`ifdef SW_INPUT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    // Edge (counted from the first edge after sw changes) at which sw_stable updates.
    localparam int E_STB = DEB - 1 + LAT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sw = 8'h00;
    logic [7:0] sw_stable;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [2:0] evt_idx;
    logic       evt_level;
    logic       evt_coalesced;
    logic       coal_clr = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    sw_input #(.WIDTH(8), .DEB_CYCLES(DEB), .FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .sw            (sw),
        .sw_stable     (sw_stable),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_idx       (evt_idx),
        .evt_level     (evt_level),
        .evt_coalesced (evt_coalesced),
        .coal_clr      (coal_clr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        #1;
        // Reset state
        do_reset();
        check_eq("rst_stable", 32'(sw_stable), 32'h0);
        check_eq("rst_valid", 32'(evt_valid), 32'h0);
        check_eq("rst_idx", 32'(evt_idx), 32'h0);
        check_eq("rst_level", 32'(evt_level), 32'h0);
        check_eq("rst_coal", 32'(evt_coalesced), 32'h0);

        // Quiet input for 20 cycles
        for (int k = 0; k < 20; k++) begin
            tick(1);
            check_eq("quiet_stable", 32'(sw_stable), 32'h0);
            check_eq("quiet_valid", 32'(evt_valid), 32'h0);
        end

        // Single rising edge on bit 3, consumer ready
        evt_ready = 1'b1;
        sw = 8'h08;
        tick(E_STB);
        check_eq("b3_pre_stable", 32'(sw_stable), 32'h00);
        tick(1);
        check_eq("b3_stable", 32'(sw_stable), 32'h08);
        check_eq("b3_pre_valid", 32'(evt_valid), 32'h0);
        tick(1);
        check_eq("b3_valid", 32'(evt_valid), 32'h1);
        check_eq("b3_idx", 32'(evt_idx), 32'h3);
        check_eq("b3_level", 32'(evt_level), 32'h1);
        tick(1);
        check_eq("b3_popped", 32'(evt_valid), 32'h0);

        // 3-cycle glitch on bit 0 is filtered
        do_reset();
        sw = 8'h01;
        tick(3);
        sw = 8'h00;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            check_eq("glitch_stable", 32'(sw_stable), 32'h0);
            check_eq("glitch_valid", 32'(evt_valid), 32'h0);
        end

        // All bits rise at once with consumer stalled
        do_reset();
        evt_ready = 1'b0;
        sw = 8'hFF;
        tick(E_STB + 1);
        check_eq("ff_stable", 32'(sw_stable), 32'hFF);
        check_eq("ff_pre_valid", 32'(evt_valid), 32'h0);
        tick(1);
        check_eq("ff_valid", 32'(evt_valid), 32'h1);
        check_eq("ff_head_idx", 32'(evt_idx), 32'h0);
        tick(12);
        check_eq("ff_hold_idx", 32'(evt_idx), 32'h0);
        check_eq("ff_hold_level", 32'(evt_level), 32'h1);
        check_eq("ff_coal0", 32'(evt_coalesced), 32'h0);

        // Bit 5 falls while still pending with the queue full
        sw = 8'hDF;
        tick(E_STB + 1);
        check_eq("coal_stable", 32'(sw_stable), 32'hDF);
        check_eq("coal_flag", 32'(evt_coalesced), 32'h1);

        // Drain: 0..7 in order, bit 5 reports its current (low) level
        evt_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check_eq("drain_valid", 32'(evt_valid), 32'h1);
            check_eq("drain_idx", 32'(evt_idx), 32'(k));
            check_eq("drain_level", 32'(evt_level), (k == 5) ? 32'h0 : 32'h1);
            tick(1);
        end
        check_eq("drain_empty", 32'(evt_valid), 32'h0);
        check_eq("coal_sticky", 32'(evt_coalesced), 32'h1);
        coal_clr = 1'b1;
        tick(1);
        coal_clr = 1'b0;
        check_eq("coal_cleared", 32'(evt_coalesced), 32'h0);

        // Mid-run reset discards three queued events
        do_reset();
        evt_ready = 1'b0;
        sw = 8'h07;
        tick(E_STB + 4);
        check_eq("pre_rst_valid", 32'(evt_valid), 32'h1);
        check_eq("pre_rst_stable", 32'(sw_stable), 32'h07);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_eq("post_rst_valid", 32'(evt_valid), 32'h0);
        check_eq("post_rst_stable", 32'(sw_stable), 32'h00);
        tick(E_STB);
        check_eq("redeb_pre_stable", 32'(sw_stable), 32'h00);
        check_eq("redeb_pre_valid", 32'(evt_valid), 32'h0);
        tick(1);
        check_eq("redeb_stable", 32'(sw_stable), 32'h07);
        tick(1);
        check_eq("redeb_valid", 32'(evt_valid), 32'h1);
        check_eq("redeb_idx", 32'(evt_idx), 32'h0);
        check_eq("redeb_level", 32'(evt_level), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
